// File: rtl/plic_claim_ctrl.sv
// Hart-side claim/complete controller for the 8-source PLIC interrupt word.
// Raises a level IRQ, runs the claim/complete handshake and masks the source in service.
module plic_claim_ctrl #(
  parameter int DRAIN_CYC = 2,
  parameter int CLAIM_TO  = 1024
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic [31:0] i_int_word,
  input  logic        i_claim,
  input  logic        i_complete,
  input  logic [2:0]  i_complete_id,
  output logic        o_irq,
  output logic        o_claim_vld,
  output logic [2:0]  o_claim_id,
  output logic        o_claim_none,
  output logic [7:0]  o_src_mask,
  output logic [7:0]  o_src_ack,
  output logic        o_busy,
  output logic        o_err,
  output logic        o_timeout
);

  localparam int TO_W = (CLAIM_TO > 2) ? $clog2(CLAIM_TO) : 1;
  localparam int DR_W = (DRAIN_CYC > 1) ? $clog2(DRAIN_CYC + 1) : 1;

  typedef enum logic [1:0] {IDLE, ASSERT, SERVICE, DRAIN} state_t;

  state_t          state, state_nxt;
  logic [31:0]     word_r;
  logic [2:0]      held_id;
  logic [TO_W-1:0] to_cnt;
  logic [DR_W-1:0] drain_cnt;

  logic       valid_r;
  logic [7:0] pend_r;
  logic [2:0] id_r;
  logic       eligible;
  logic       claim_take, cmpl_ok, err_hit, timeout_hit;
  logic       unused_word_bits;

  assign valid_r  = word_r[0];
  assign pend_r   = word_r[15:8];
  assign id_r     = word_r[26:24];
  assign eligible = valid_r & pend_r[id_r] & ~o_src_mask[id_r];
  assign unused_word_bits = ^{word_r[31:27], word_r[23:16], word_r[7:1]};

  assign o_irq  = (state == ASSERT);
  assign o_busy = (state == SERVICE) || (state == DRAIN);

  always_comb begin
    state_nxt   = state;
    claim_take  = 1'b0;
    cmpl_ok     = 1'b0;
    err_hit     = 1'b0;
    timeout_hit = 1'b0;
    case (state)
      IDLE: begin
        if (eligible) state_nxt = ASSERT;
      end
      ASSERT: begin
        // A claim beats a withdraw or a timeout landing in the same cycle.
        if (i_claim) begin
          claim_take = 1'b1;
          state_nxt  = SERVICE;
        end else if (!valid_r || !pend_r[held_id]) begin
          state_nxt = IDLE;
        end else if (to_cnt == TO_W'(CLAIM_TO - 1)) begin
          timeout_hit = 1'b1;
        end
      end
      SERVICE: begin
        if (i_complete) begin
          if (i_complete_id == held_id) begin
            cmpl_ok   = 1'b1;
            state_nxt = DRAIN;
          end else begin
            err_hit = 1'b1;
          end
        end
      end
      DRAIN: begin
        if (drain_cnt == '0) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    if (i_complete && (state != SERVICE)) err_hit = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= IDLE;
      word_r       <= '0;
      held_id      <= '0;
      to_cnt       <= '0;
      drain_cnt    <= '0;
      o_claim_vld  <= 1'b0;
      o_claim_id   <= '0;
      o_claim_none <= 1'b0;
      o_src_mask   <= '0;
      o_src_ack    <= '0;
      o_err        <= 1'b0;
      o_timeout    <= 1'b0;
    end else begin
      state  <= state_nxt;
      word_r <= i_int_word;
      if (state == IDLE && eligible) held_id <= id_r;

      to_cnt <= (state == ASSERT && state_nxt == ASSERT && !timeout_hit) ?
                to_cnt + TO_W'(1) : '0;

      // Drain covers the PLIC output register and word_r still showing the old source.
      if (cmpl_ok)
        drain_cnt <= DR_W'(DRAIN_CYC - 1);
      else if (state == DRAIN && drain_cnt != '0)
        drain_cnt <= drain_cnt - DR_W'(1);

      o_claim_vld  <= i_claim;
      o_claim_none <= i_claim & ~claim_take;
      o_claim_id   <= claim_take ? held_id : 3'd0;
      o_src_ack    <= claim_take ? (8'h01 << held_id) : 8'h00;
      if (claim_take)
        o_src_mask <= 8'h01 << held_id;
      else if (cmpl_ok)
        o_src_mask <= 8'h00;
      o_err     <= err_hit;
      o_timeout <= timeout_hit;
    end
  end

endmodule

// File: tb/tb_plic_claim_ctrl.sv
// Directed bench for plic_claim_ctrl with DRAIN_CYC=2 and CLAIM_TO=8.
module tb_plic_claim_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] int_word;
  logic        claim, complete;
  logic [2:0]  complete_id;
  logic        irq, claim_vld, claim_none, busy, err, timeout;
  logic [2:0]  claim_id;
  logic [7:0]  src_mask, src_ack;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  plic_claim_ctrl #(.DRAIN_CYC(2), .CLAIM_TO(8)) dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_int_word(int_word),
    .i_claim(claim), .i_complete(complete), .i_complete_id(complete_id),
    .o_irq(irq), .o_claim_vld(claim_vld), .o_claim_id(claim_id),
    .o_claim_none(claim_none), .o_src_mask(src_mask), .o_src_ack(src_ack),
    .o_busy(busy), .o_err(err), .o_timeout(timeout)
  );

  task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_vec({tag, "_irq"}, irq, 0);
    check_vec({tag, "_vld"}, claim_vld, 0);
    check_vec({tag, "_mask"}, src_mask, 0);
    check_vec({tag, "_ack"}, src_ack, 0);
    check_vec({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    rst_n = 1'b0; int_word = '0; claim = 1'b0; complete = 1'b0; complete_id = '0;
    #12;
    check_quiet("rst");
    check_vec("rst_err", err, 0);
    check_vec("rst_to", timeout, 0);
    check_vec("rst_id", claim_id, 0);
    check_vec("rst_none", claim_none, 0);
    tick;
    rst_n = 1'b1;

    // Basic handshake, id 3
    int_word = 32'h0300_0801;
    tick; check_vec("hs_irq_n1", irq, 0);
    tick; check_vec("hs_irq_n2", irq, 1);
    tick; check_vec("hs_irq_n3", irq, 1);
    tick; check_vec("hs_irq_n4", irq, 1);
    claim = 1'b1;
    tick; claim = 1'b0;
    check_vec("hs_vld", claim_vld, 1);
    check_vec("hs_id", claim_id, 3);
    check_vec("hs_none", claim_none, 0);
    check_vec("hs_ack", src_ack, 8'h08);
    check_vec("hs_mask", src_mask, 8'h08);
    check_vec("hs_irq_drop", irq, 0);
    check_vec("hs_busy", busy, 1);
    tick;
    check_vec("hs_ack_clr", src_ack, 0);
    check_vec("hs_vld_clr", claim_vld, 0);
    check_vec("hs_mask_hold", src_mask, 8'h08);
    complete = 1'b1; complete_id = 3'd3; int_word = '0;
    tick; complete = 1'b0;
    check_vec("hs_cmpl_mask", src_mask, 0);
    check_vec("hs_cmpl_err", err, 0);
    check_vec("hs_drain1", busy, 1);
    tick; check_vec("hs_drain2", busy, 1);
    tick; check_vec("hs_idle", busy, 0);
    check_vec("hs_idle_irq", irq, 0);
    tick;

    // Withdraw after 3 cycles, id 5
    int_word = 32'h0500_2001;
    begin
      logic [5:0] exp_irq;
      exp_irq = 6'b001110;
      for (int i = 0; i < 6; i++) begin
        if (i == 3) int_word = '0;
        tick;
        check_vec("wd_irq", irq, exp_irq[i]);
        check_vec("wd_ack", src_ack, 0);
        check_vec("wd_vld", claim_vld, 0);
      end
    end

    // Spurious claim in IDLE
    claim = 1'b1;
    tick; claim = 1'b0;
    check_vec("sp_vld", claim_vld, 1);
    check_vec("sp_none", claim_none, 1);
    check_vec("sp_id", claim_id, 0);
    check_vec("sp_ack", src_ack, 0);
    check_vec("sp_busy", busy, 0);
    tick; check_vec("sp_vld_clr", claim_vld, 0);

    // Mismatched complete in SERVICE, id 2
    int_word = 32'h0200_0401;
    tick; tick; check_vec("mm_irq", irq, 1);
    claim = 1'b1;
    tick; claim = 1'b0;
    check_vec("mm_id", claim_id, 2);
    check_vec("mm_mask", src_mask, 8'h04);
    complete = 1'b1; complete_id = 3'd4;
    tick; complete = 1'b0;
    check_vec("mm_err", err, 1);
    check_vec("mm_mask_hold", src_mask, 8'h04);
    check_vec("mm_busy", busy, 1);
    tick; check_vec("mm_err_clr", err, 0);
    // Claim and complete together in SERVICE
    claim = 1'b1; complete = 1'b1; complete_id = 3'd2; int_word = '0;
    tick; claim = 1'b0; complete = 1'b0;
    check_vec("cc_mask", src_mask, 0);
    check_vec("cc_vld", claim_vld, 1);
    check_vec("cc_none", claim_none, 1);
    check_vec("cc_ack", src_ack, 0);
    check_vec("cc_err", err, 0);
    // Complete during DRAIN is an error
    complete = 1'b1; complete_id = 3'd2;
    tick; complete = 1'b0;
    check_vec("dr_err", err, 1);
    check_vec("dr_busy", busy, 1);
    tick; check_vec("dr_idle", busy, 0);
    tick;

    // Masked re-arm, id 1
    int_word = 32'h0100_0201;
    tick; tick; check_vec("ra_irq", irq, 1);
    claim = 1'b1;
    tick; claim = 1'b0;
    check_vec("ra_mask", src_mask, 8'h02);
    for (int i = 0; i < 4; i++) begin
      tick;
      check_vec("ra_masked_irq", irq, 0);
    end
    complete = 1'b1; complete_id = 3'd1;
    tick; complete = 1'b0;
    check_vec("ra_mask_clr", src_mask, 0);
    check_vec("ra_irq_e0", irq, 0);
    tick; check_vec("ra_irq_e1", irq, 0);
    tick; check_vec("ra_irq_e2", irq, 0);
    tick; check_vec("ra_irq_e3", irq, 1);

    // Timeout with CLAIM_TO=8, word still held
    for (int k = 1; k <= 17; k++) begin
      tick;
      check_vec("to_pulse", timeout, (k == 8 || k == 16) ? 1 : 0);
      check_vec("to_irq", irq, 1);
    end

    // Reset mid-SERVICE
    claim = 1'b1;
    tick; claim = 1'b0;
    check_vec("rs_pre_mask", src_mask, 8'h02);
    check_vec("rs_pre_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    check_quiet("rs_async");
    check_vec("rs_async_id", claim_id, 0);
    tick;
    check_quiet("rs_hold");
    int_word = '0;
    rst_n = 1'b1;
    tick;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

endmodule
